// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: turns [CMD][DATA] (or [CMD][DATA][CHK]) byte frames into register strobes.
// Optional checksum byte is built only when SPI_FRM_CHKSUM_EN is defined.
module spi_frame_decoder #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_vld,
    input  logic              frm_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frm_done,
    output logic              frm_err,
    output logic [7:0]        frm_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        GOT_CMD,
`ifdef SPI_FRM_CHKSUM_EN
        GOT_DATA,
`endif
        EXEC
    } state_t;

    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [7:0]      CHK_KEY  = 8'hA5;

    state_t     state, state_nxt;
    logic       vld_q;
    logic       accept;
    logic [7:0] cmd_q;
    logic [7:0] data_q;
    logic       frame_ok;
`ifdef SPI_FRM_CHKSUM_EN
    logic       chk_ok_q;
`endif

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < ADDR_LIM;
    endfunction

    // Level-valid from the deserializer: only the rising edge counts as a new byte.
    assign accept = byte_vld & ~vld_q;

`ifdef SPI_FRM_CHKSUM_EN
    assign frame_ok = addr_ok(cmd_q[ADDR_W-1:0]) & chk_ok_q;
`else
    assign frame_ok = addr_ok(cmd_q[ADDR_W-1:0]);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frm_clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = GOT_CMD;
`ifdef SPI_FRM_CHKSUM_EN
                GOT_CMD:  if (accept) state_nxt = GOT_DATA;
                GOT_DATA: if (accept) state_nxt = EXEC;
`else
                GOT_CMD: if (accept) state_nxt = EXEC;
`endif
                EXEC:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            cmd_q  <= '0;
            data_q <= '0;
`ifdef SPI_FRM_CHKSUM_EN
            chk_ok_q <= 1'b0;
`endif
        end else begin
            vld_q <= byte_vld;
            if (accept && !frm_clr) begin
                case (state)
                    IDLE:     cmd_q  <= byte_in;
                    GOT_CMD:  data_q <= byte_in;
`ifdef SPI_FRM_CHKSUM_EN
                    GOT_DATA: chk_ok_q <= (byte_in == (cmd_q ^ data_q ^ CHK_KEY));
`endif
                    default: ;
                endcase
            end
        end
    end

    // All strobes are registered; a concurrent frm_clr suppresses any pending strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
            frm_cnt  <= '0;
        end else begin
            wr_en    <= 1'b0;
            rd_req   <= 1'b0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
            if (!frm_clr) begin
                if (state == IDLE && accept && byte_in[7] && addr_ok(byte_in[ADDR_W-1:0])) begin
                    rd_req  <= 1'b1;
                    rd_addr <= byte_in[ADDR_W-1:0];
                end
                if (state == EXEC) begin
                    if (frame_ok) begin
                        frm_done <= 1'b1;
                        frm_cnt  <= frm_cnt + 8'd1;
                        if (!cmd_q[7]) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cmd_q[ADDR_W-1:0];
                            wr_data <= data_q;
                        end
                    end else begin
                        frm_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb_spi_frame_decoder: directed and randomized frames checked against a frame-level reference model.
// Follows the DUT build: define SPI_FRM_CHKSUM_EN for both to exercise the checksum byte.
module tb_spi_frame_decoder;

    localparam int NUM_REGS = 16;
`ifdef SPI_FRM_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_vld = 1'b0;
    logic       frm_clr = 1'b0;
    logic       wr_en, rd_req, frm_done, frm_err;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data, frm_cnt;

    spi_frame_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .frm_clr(frm_clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .frm_done(frm_done), .frm_err(frm_err), .frm_cnt(frm_cnt)
    );

    always #5 clk = ~clk;

    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned n_wr = 0, n_rd = 0, n_done = 0, n_err = 0;
    int unsigned wr_cyc = 0, rd_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [6:0]  mon_wa = '0, mon_ra = '0;
    logic [7:0]  mon_wd = '0;

    // Reference model state: what the outputs must hold after each frame.
    logic [7:0] m_cnt = '0, m_wd = '0;
    logic [6:0] m_wa = '0, m_ra = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // cyc seen at a negedge is the index of the current cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en)    begin n_wr++; wr_cyc = cyc; mon_wa = wr_addr; mon_wd = wr_data; end
            if (rd_req)   begin n_rd++; rd_cyc = cyc; mon_ra = rd_addr; end
            if (frm_done) begin n_done++; done_cyc = cyc; end
            if (frm_err)  begin n_err++; err_cyc = cyc; end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned hold);
        @(negedge clk);
        byte_in  = b;
        byte_vld = 1'b1;
        acc_cyc  = cyc;
        repeat (hold) @(negedge clk);
        byte_vld = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                         input int unsigned hold);
        int unsigned w0, r0, d0, e0, a_cmd, a_last;
        bit aok, ok, exp_wr, exp_rd;
        w0 = n_wr; r0 = n_rd; d0 = n_done; e0 = n_err;
        send_byte(c, hold); a_cmd = acc_cyc;
        send_byte(d, hold); a_last = acc_cyc;
        if (CHK_EN) begin
            send_byte(k, hold); a_last = acc_cyc;
        end
        aok    = int'(c[6:0]) < NUM_REGS;
        ok     = aok && (!CHK_EN || k == (c ^ d ^ 8'hA5));
        exp_rd = c[7] && aok;
        exp_wr = ok && !c[7];
        if (ok) m_cnt = m_cnt + 8'd1;
        if (exp_wr) begin m_wa = c[6:0]; m_wd = d; end
        if (exp_rd) m_ra = c[6:0];
        check("wr_count",   n_wr - w0,   32'(exp_wr));
        check("rd_count",   n_rd - r0,   32'(exp_rd));
        check("done_count", n_done - d0, 32'(ok));
        check("err_count",  n_err - e0,  32'(!ok));
        if (exp_wr) begin
            check("wr_latency", wr_cyc, a_last + 2);
            check("wr_addr_strobe", 32'(mon_wa), 32'(m_wa));
            check("wr_data_strobe", 32'(mon_wd), 32'(m_wd));
        end
        if (exp_rd) begin
            check("rd_latency", rd_cyc, a_cmd + 1);
            check("rd_addr_strobe", 32'(mon_ra), 32'(m_ra));
        end
        if (ok) check("done_latency", done_cyc, a_last + 2);
        else    check("err_latency",  err_cyc,  a_last + 2);
        check("wr_addr_hold", 32'(wr_addr), 32'(m_wa));
        check("wr_data_hold", 32'(wr_data), 32'(m_wd));
        check("rd_addr_hold", 32'(rd_addr), 32'(m_ra));
        check("frm_cnt",      32'(frm_cnt), 32'(m_cnt));
    endtask

    function automatic logic [7:0] good_chk(input logic [7:0] c, input logic [7:0] d);
        return c ^ d ^ 8'hA5;
    endfunction

    task automatic reset_model();
        m_cnt = '0; m_wa = '0; m_wd = '0; m_ra = '0;
    endtask

    initial begin
        int unsigned w0, r0, d0, e0;
        logic [7:0] c, d, k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en",  32'(wr_en), 0);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_done",   32'(frm_done), 0);
        check("rst_err",    32'(frm_err), 0);
        check("rst_cnt",    32'(frm_cnt), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write, read, bad address
        frame(8'h05, 8'h3C, 8'h9C, 1);
        frame(8'h83, 8'hFF, good_chk(8'h83, 8'hFF), 2);
        frame(8'h20, 8'h11, good_chk(8'h20, 8'h11), 1);
        frame(8'h0F, 8'h5A, good_chk(8'h0F, 8'h5A), 1);
        frame(8'h10, 8'h5A, good_chk(8'h10, 8'h5A), 1);
        frame(8'h90, 8'h00, good_chk(8'h90, 8'h00), 1);
        if (CHK_EN) frame(8'h05, 8'h3C, 8'h00, 1);

        // Abort a partial frame, then a clean frame
        w0 = n_wr; r0 = n_rd; d0 = n_done; e0 = n_err;
        send_byte(8'h05, 1);
        @(negedge clk); frm_clr = 1'b1;
        @(negedge clk); frm_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_strobe", (n_wr - w0) + (n_rd - r0) + (n_done - d0) + (n_err - e0), 0);
        frame(8'h01, 8'hAA, good_chk(8'h01, 8'hAA), 1);

        // frm_clr coinciding with a byte edge drops that byte
        w0 = n_wr; d0 = n_done; e0 = n_err;
        send_byte(8'h07, 1);
        @(negedge clk); byte_in = 8'h3C; byte_vld = 1'b1; frm_clr = 1'b1;
        @(negedge clk); frm_clr = 1'b0;
        @(negedge clk); byte_vld = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_wins_no_strobe", (n_wr - w0) + (n_done - d0) + (n_err - e0), 0);
        frame(8'h02, 8'h11, good_chk(8'h02, 8'h11), 1);

        // byte_vld held high 20 cycles counts once
        frame(8'h02, 8'h77, good_chk(8'h02, 8'h77), 20);

        // Randomized frames
        for (int i = 0; i < 60; i++) begin
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) c[6:0] = 7'($urandom_range(0, NUM_REGS - 1));
            d = 8'($urandom_range(0, 255));
            k = good_chk(c, d);
            if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
            frame(c, d, k, $urandom_range(1, 3));
        end

        // Reset in the middle of a frame
        send_byte(8'h04, 1);
        @(negedge clk); byte_in = 8'h66; byte_vld = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_cnt",   32'(frm_cnt), 0);
        check("midrst_wr_addr", 32'(wr_addr), 0);
        check("midrst_rd_addr", 32'(rd_addr), 0);
        byte_vld = 1'b0;
        @(negedge clk); rst = 1'b1;
        reset_model();
        repeat (4) @(negedge clk);

        // 256 good frames wrap the counter back to 0
        for (int i = 0; i < 256; i++) begin
            c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, NUM_REGS - 1))};
            d = 8'($urandom_range(0, 255));
            frame(c, d, good_chk(c, d), 1);
        end
        check("cnt_wrap", 32'(frm_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
